// File: rtl/dual_cic_interpolator.sv
// Dual (I/Q) 3-stage CIC interpolator: one shared rate counter and register block.
// Each lane runs comb at the capture rate and integrators at the clkEn rate.
`ifndef CICINTSPACE
`define CICINTSPACE 13'b1_0000_000?_????
`endif

module cic_int_lane (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic               cap,
  input  logic               first,
  input  logic [5:0]         shamt,
  input  logic signed [17:0] x,
  output logic signed [17:0] y
);
  logic signed [47:0] xs, xd, c1d, c2d, comb_out;
  logic signed [47:0] c1, c2, c3, u, int1, int2, int3, sh;

  assign xs = 48'(x);
  assign c1 = xs - xd;
  assign c2 = c1 - c1d;
  assign c3 = c2 - c2d;
  // Zero-stuffing: the comb result enters the integrators once per capture.
  assign u  = first ? comb_out : '0;
  assign sh = int3 >>> shamt;

  always_ff @(posedge clk) begin
    if (reset) begin
      xd <= '0; c1d <= '0; c2d <= '0; comb_out <= '0;
      int1 <= '0; int2 <= '0; int3 <= '0; y <= '0;
    end else if (en) begin
      if (cap) begin
        xd       <= xs;
        c1d      <= c1;
        c2d      <= c2;
        comb_out <= c3;
      end
      int1 <= int1 + u;
      int2 <= int2 + int1;
      int3 <= int3 + int2;
      if (sh > 48'sd131071)       y <= 18'sd131071;
      else if (sh < -48'sd131072) y <= -18'sd131072;
      else                        y <= sh[17:0];
    end
  end
endmodule

module dual_cic_interpolator #(
  parameter logic [12:0] RegSpace = `CICINTSPACE
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clkEn,
  input  logic               wr0,
  input  logic               wr1,
  input  logic               wr2,
  input  logic               wr3,
  input  logic [12:0]        addr,
  input  logic [31:0]        din,
  output logic [31:0]        dout,
  input  logic signed [17:0] inI,
  input  logic signed [17:0] inQ,
  output logic               clkEnReq,
  output logic signed [17:0] outI,
  output logic signed [17:0] outQ,
  output logic               clkEnOut
);
  localparam int NUM_LANES = 2;
  localparam int VEC_W     = 18;

  logic        cs;
  logic [11:0] interp, cnt;
  logic [5:0]  shift_r, shamt;
  logic        first;
  logic [NUM_LANES-1:0][VEC_W-1:0] lane_in, lane_out;
  logic        unused;

  assign unused = ^{din[31:12], wr2, wr3};

  always_comb begin
    cs = 1'b0;
    casez (addr)
      RegSpace: cs = 1'b1;
      default:  cs = 1'b0;
    endcase
  end

  always_comb begin
    dout = '0;
    if (cs) begin
      case (addr[4:2])
        3'd0:    dout = {20'd0, interp};
        3'd1:    dout = {26'd0, shift_r};
        default: dout = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      interp  <= '0;
      shift_r <= '0;
    end else if (cs) begin
      if (addr[4:2] == 3'd0) begin
        if (wr0) interp[7:0]  <= din[7:0];
        if (wr1) interp[11:8] <= din[11:8];
      end
      if (addr[4:2] == 3'd1 && wr0) shift_r <= din[5:0];
    end
  end

  assign clkEnReq = clkEn & ~reset & (cnt == 12'd0);
  assign shamt    = (shift_r > 6'd47) ? 6'd47 : shift_r;

  // Reload reads the pre-write interp, so a coincident write waits one period.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt      <= '0;
      first    <= 1'b0;
      clkEnOut <= 1'b0;
    end else begin
      clkEnOut <= clkEn;
      if (clkEn) begin
        first <= clkEnReq;
        cnt   <= clkEnReq ? interp : cnt - 12'd1;
      end
    end
  end

  assign lane_in[0] = inI;
  assign lane_in[1] = inQ;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    cic_int_lane u_lane (
      .clk   (clk),
      .reset (reset),
      .en    (clkEn),
      .cap   (clkEnReq),
      .first (first),
      .shamt (shamt),
      .x     (lane_in[g]),
      .y     (lane_out[g])
    );
  end

  assign outI = lane_out[0];
  assign outQ = lane_out[1];
endmodule
